// File: rtl/pwl_pkg.sv
// Shared definitions for the piecewise-linear activation coefficient path.
// The word length here matches the fixed-point format of the tanh/sigmoid evaluators.
package pwl_pkg;

  localparam int PWL_WL    = 16;
  localparam int PWL_NSEG  = 10;
  localparam int PWL_IDX_W = $clog2(PWL_NSEG);

  // Loader sequencing: slope word, then intercept word, per segment.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD_A = 2'd1,
    LOAD_B = 2'd2,
    COMMIT = 2'd3
  } pwl_state_e;

  // Selects which half of a segment entry a write targets.
  typedef enum logic {
    SEL_SLOPE     = 1'b0,
    SEL_INTERCEPT = 1'b1
  } pwl_wsel_e;

endpackage

// File: rtl/pwl_coef_bank.sv
// One bank of the PWL segment table: NSEG slopes plus NSEG intercepts.
// Synchronous write and clear, combinational read; the loader owns muxing.
module pwl_coef_bank
  import pwl_pkg::*;
#(
  parameter int  WL    = PWL_WL,
  parameter int  NSEG  = PWL_NSEG,
  localparam int IDX_W = $clog2(NSEG)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [IDX_W-1:0] widx,
  input  pwl_wsel_e        wsel,
  input  logic [WL-1:0]    wdata,
  input  logic [IDX_W-1:0] ridx,
  output logic [WL-1:0]    rslope,
  output logic [WL-1:0]    rintercept
);

  logic [WL-1:0] slope_r     [NSEG];
  logic [WL-1:0] intercept_r [NSEG];

  // Table storage: cleared on reset, one half-entry written per enabled cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NSEG; i++) begin
        slope_r[i]     <= {WL{1'b0}};
        intercept_r[i] <= {WL{1'b0}};
      end
    end else if (we) begin
      if (wsel == SEL_SLOPE) begin
        slope_r[widx] <= wdata;
      end else begin
        intercept_r[widx] <= wdata;
      end
    end
  end

  assign rslope     = slope_r[ridx];
  assign rintercept = intercept_r[ridx];

endmodule

// File: rtl/pwl_coef_loader.sv
// Double-buffered PWL coefficient loader. A serial a0,b0,a1,b1,... stream
// fills the shadow bank; a one-cycle COMMIT swaps banks atomically so the
// evaluators only ever read a complete table.
module pwl_coef_loader
  import pwl_pkg::*;
#(
  parameter int  WL    = PWL_WL,
  parameter int  NSEG  = PWL_NSEG,
  localparam int IDX_W = $clog2(NSEG)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_req,
  input  logic             abort,
  input  logic             s_valid,
  input  logic [WL-1:0]    s_data,
  output logic             s_ready,
  output logic             busy,
  output logic             load_done,
  output logic             table_valid,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [WL-1:0]    rd_slope,
  output logic [WL-1:0]    rd_intercept
);

  localparam logic [IDX_W-1:0] LAST_SEG = IDX_W'(NSEG - 1);

  // Out-of-range indices fall into the last (catch-all) segment.
  function automatic logic [IDX_W-1:0] clamp_idx(input logic [IDX_W-1:0] idx);
    if (int'(idx) >= NSEG) begin
      return LAST_SEG;
    end else begin
      return idx;
    end
  endfunction

  pwl_state_e       state_r, state_nxt_s;
  logic [IDX_W-1:0] seg_cnt_r, seg_cnt_nxt_s;
  logic             bank_sel_r;
  logic             load_done_r;
  logic             table_valid_r;
  logic             s_ready_r;
  logic             busy_r;
  logic [WL-1:0]    rd_slope_r;
  logic [WL-1:0]    rd_intercept_r;

  logic             wr_en_s;
  pwl_wsel_e        wsel_s;
  logic             commit_s;
  logic             we0_s;
  logic             we1_s;
  logic [IDX_W-1:0] rd_idx_clamp_s;
  logic [WL-1:0]    b0_slope_s, b0_intercept_s;
  logic [WL-1:0]    b1_slope_s, b1_intercept_s;

  // Next-state, segment counter and write strobe; abort beats a same-cycle word.
  always_comb begin
    state_nxt_s   = state_r;
    seg_cnt_nxt_s = seg_cnt_r;
    wr_en_s       = 1'b0;
    wsel_s        = SEL_SLOPE;
    commit_s      = 1'b0;
    case (state_r)
      IDLE: begin
        if (load_req) begin
          state_nxt_s   = LOAD_A;
          seg_cnt_nxt_s = {IDX_W{1'b0}};
        end else begin
          state_nxt_s = IDLE;
        end
      end
      LOAD_A: begin
        if (abort) begin
          state_nxt_s   = IDLE;
          seg_cnt_nxt_s = {IDX_W{1'b0}};
        end else if (s_valid) begin
          wr_en_s     = 1'b1;
          wsel_s      = SEL_SLOPE;
          state_nxt_s = LOAD_B;
        end else begin
          state_nxt_s = LOAD_A;
        end
      end
      LOAD_B: begin
        if (abort) begin
          state_nxt_s   = IDLE;
          seg_cnt_nxt_s = {IDX_W{1'b0}};
        end else if (s_valid) begin
          wr_en_s = 1'b1;
          wsel_s  = SEL_INTERCEPT;
          if (seg_cnt_r == LAST_SEG) begin
            state_nxt_s = COMMIT;
          end else begin
            seg_cnt_nxt_s = seg_cnt_r + IDX_W'(1'b1);
            state_nxt_s   = LOAD_A;
          end
        end else begin
          state_nxt_s = LOAD_B;
        end
      end
      COMMIT: begin
        commit_s      = 1'b1;
        state_nxt_s   = IDLE;
        seg_cnt_nxt_s = {IDX_W{1'b0}};
      end
      default: begin
        state_nxt_s   = IDLE;
        seg_cnt_nxt_s = {IDX_W{1'b0}};
      end
    endcase
  end

  // Control registers; status outputs are registered from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= IDLE;
      seg_cnt_r     <= {IDX_W{1'b0}};
      bank_sel_r    <= 1'b0;
      load_done_r   <= 1'b0;
      table_valid_r <= 1'b0;
      s_ready_r     <= 1'b0;
      busy_r        <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      seg_cnt_r   <= seg_cnt_nxt_s;
      load_done_r <= commit_s;
      s_ready_r   <= (state_nxt_s == LOAD_A) || (state_nxt_s == LOAD_B);
      busy_r      <= (state_nxt_s != IDLE);
      if (commit_s) begin
        bank_sel_r    <= ~bank_sel_r;
        table_valid_r <= 1'b1;
      end
    end
  end

  // Writes go only to the shadow bank, i.e. the one not selected for reading.
  assign we0_s          = wr_en_s & bank_sel_r;
  assign we1_s          = wr_en_s & ~bank_sel_r;
  assign rd_idx_clamp_s = clamp_idx(rd_idx);

  pwl_coef_bank #(.WL(WL), .NSEG(NSEG)) u_bank0 (
    .clk        (clk),
    .rst        (rst),
    .we         (we0_s),
    .widx       (seg_cnt_r),
    .wsel       (wsel_s),
    .wdata      (s_data),
    .ridx       (rd_idx_clamp_s),
    .rslope     (b0_slope_s),
    .rintercept (b0_intercept_s)
  );

  pwl_coef_bank #(.WL(WL), .NSEG(NSEG)) u_bank1 (
    .clk        (clk),
    .rst        (rst),
    .we         (we1_s),
    .widx       (seg_cnt_r),
    .wsel       (wsel_s),
    .wdata      (s_data),
    .ridx       (rd_idx_clamp_s),
    .rslope     (b1_slope_s),
    .rintercept (b1_intercept_s)
  );

  // Read port: one-cycle latency from the bank that is active at the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_slope_r     <= {WL{1'b0}};
      rd_intercept_r <= {WL{1'b0}};
    end else begin
      rd_slope_r     <= bank_sel_r ? b1_slope_s : b0_slope_s;
      rd_intercept_r <= bank_sel_r ? b1_intercept_s : b0_intercept_s;
    end
  end

  assign s_ready      = s_ready_r;
  assign busy         = busy_r;
  assign load_done    = load_done_r;
  assign table_valid  = table_valid_r;
  assign rd_slope     = rd_slope_r;
  assign rd_intercept = rd_intercept_r;

endmodule

// File: tb/tb_pwl_coef_loader.sv
// Scoreboard bench for pwl_coef_loader: stimulus pushes expectations,
// a negedge monitor pops and compares reads, status and load_done pulses.
module tb_pwl_coef_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        load_req;
  logic        abort;
  logic        s_valid;
  logic [15:0] s_data;
  logic        s_ready;
  logic        busy;
  logic        load_done;
  logic        table_valid;
  logic [3:0]  rd_idx;
  logic [15:0] rd_slope;
  logic [15:0] rd_intercept;

  always #5 clk = ~clk;

  pwl_coef_loader dut (
    .clk          (clk),
    .rst          (rst),
    .load_req     (load_req),
    .abort        (abort),
    .s_valid      (s_valid),
    .s_data       (s_data),
    .s_ready      (s_ready),
    .busy         (busy),
    .load_done    (load_done),
    .table_valid  (table_valid),
    .rd_idx       (rd_idx),
    .rd_slope     (rd_slope),
    .rd_intercept (rd_intercept)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic rd_req  = 1'b0;
  logic rd_pend = 1'b0;
  logic st_req  = 1'b0;

  logic [31:0] rd_q[$];
  string       rd_name_q[$];
  logic [2:0]  st_q[$];
  string       st_name_q[$];
  int          done_q[$];

  logic [31:0] exp_rd;
  logic [2:0]  exp_st;
  int          exp_cyc;
  string       nm;

  // Cycle counter and one-cycle delay of the read request (read latency).
  always @(posedge clk) begin
    cyc     <= cyc + 1;
    rd_pend <= rd_req;
  end

  // Monitor: pop and compare whenever the DUT presents a result.
  always @(negedge clk) begin
    if (rd_pend) begin
      if (rd_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL rd_unexpected: no expectation queued");
      end else begin
        exp_rd = rd_q.pop_front();
        nm     = rd_name_q.pop_front();
        checks++;
        if ({rd_slope, rd_intercept} !== exp_rd) begin
          errors++;
          $display("FAIL %s: got slope=%h intercept=%h, expected slope=%h intercept=%h",
                   nm, rd_slope, rd_intercept, exp_rd[31:16], exp_rd[15:0]);
        end
      end
    end
    if (st_req) begin
      exp_st = st_q.pop_front();
      nm     = st_name_q.pop_front();
      checks++;
      if ({busy, table_valid, s_ready} !== exp_st) begin
        errors++;
        $display("FAIL %s: got busy=%b table_valid=%b s_ready=%b, expected busy=%b table_valid=%b s_ready=%b",
                 nm, busy, table_valid, s_ready, exp_st[2], exp_st[1], exp_st[0]);
      end
    end
    if (load_done === 1'b1) begin
      checks++;
      if (done_q.size() == 0) begin
        errors++;
        $display("FAIL load_done_unexpected: pulse at cycle %0d, expected none", cyc);
      end else begin
        exp_cyc = done_q.pop_front();
        if (cyc != exp_cyc) begin
          errors++;
          $display("FAIL load_done_cycle: got cycle %0d, expected cycle %0d", cyc, exp_cyc);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    rd_req = 1'b0;
    st_req = 1'b0;
  endtask

  task automatic chk_status(input string name, input logic b, input logic tv, input logic r);
    st_q.push_back({b, tv, r});
    st_name_q.push_back(name);
    st_req = 1'b1;
  endtask

  task automatic do_read(input logic [3:0] idx, input logic [15:0] es, input logic [15:0] ei,
                         input string name);
    rd_idx = idx;
    rd_q.push_back({es, ei});
    rd_name_q.push_back(name);
    rd_req = 1'b1;
    tick();
  endtask

  task automatic send_word(input logic [15:0] d, input logic ab, output int hs);
    int n;
    n       = 0;
    s_data  = d;
    s_valid = 1'b1;
    abort   = ab;
    while (!s_ready && n < 50) begin
      tick();
      n++;
    end
    if (!s_ready) begin
      checks++; errors++;
      $display("FAIL send_timeout: s_ready=%b after %0d cycles, expected 1", s_ready, n);
    end
    hs = cyc;
    tick();
    s_valid = 1'b0;
    abort   = 1'b0;
  endtask

  // Watchdog so a stuck run still terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    int hs;
    int first;
    rst      = 1'b1;
    load_req = 1'b0;
    abort    = 1'b0;
    s_valid  = 1'b0;
    s_data   = 16'h0000;
    rd_idx   = 4'd0;
    repeat (3) tick();
    rst = 1'b0;

    // Reset state and empty table.
    chk_status("reset_status", 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      do_read(4'(i), 16'h0000, 16'h0000, "reset_read");
    end

    // Load 1: a_i=i+1, b_i=100+i, valid always high.
    load_req = 1'b1; tick(); load_req = 1'b0;
    chk_status("load1_busy", 1'b1, 1'b0, 1'b1);
    first = 0;
    for (int i = 0; i < 10; i++) begin
      send_word(16'(i + 1), 1'b0, hs);
      if (i == 0) begin
        first = hs;
        done_q.push_back(first + 21);
      end
      send_word(16'(100 + i), 1'b0, hs);
    end
    tick();
    chk_status("load1_done_status", 1'b0, 1'b1, 1'b0);
    do_read(4'd3,  16'd4,  16'd103, "load1_idx3");
    do_read(4'd15, 16'd10, 16'd109, "load1_idx15_clamp");
    do_read(4'd0,  16'd1,  16'd100, "load1_idx0");
    do_read(4'd9,  16'd10, 16'd109, "load1_idx9");

    // Load 2: valid toggles, old table visible throughout.
    load_req = 1'b1; tick(); load_req = 1'b0;
    for (int i = 0; i < 10; i++) begin
      send_word(16'(16'h0200 + i), 1'b0, hs);
      if (i == 4) begin
        chk_status("load2_stall_status", 1'b1, 1'b1, 1'b1);
      end
      do_read(4'd3, 16'd4, 16'd103, "load2_old_table");
      send_word(16'(16'h0300 + i), 1'b0, hs);
      if (i < 9) begin
        do_read(4'd3, 16'd4, 16'd103, "load2_old_table");
      end
    end
    done_q.push_back(hs + 2);
    tick();
    chk_status("load2_done_status", 1'b0, 1'b1, 1'b0);
    do_read(4'd3, 16'h0203, 16'h0303, "load2_idx3");
    do_read(4'd2, 16'h0202, 16'h0302, "load2_idx2");

    // Abort coincident with the 8th valid word.
    load_req = 1'b1; tick(); load_req = 1'b0;
    for (int k = 0; k < 7; k++) begin
      send_word(16'(16'h0700 + k), 1'b0, hs);
    end
    send_word(16'h0777, 1'b1, hs);
    chk_status("abort_idle", 1'b0, 1'b1, 1'b0);
    do_read(4'd2, 16'h0202, 16'h0302, "abort_table_kept");
    tick();

    // Load 3: stray load_req at word 5, abort during COMMIT, read across the swap.
    load_req = 1'b1; tick(); load_req = 1'b0;
    for (int w = 0; w < 20; w++) begin
      if (w == 5) begin
        load_req = 1'b1;
      end
      if (w % 2 == 0) begin
        send_word(16'(16'h0400 + w / 2), 1'b0, hs);
      end else begin
        send_word(16'(16'h0500 + w / 2), 1'b0, hs);
      end
      load_req = 1'b0;
    end
    done_q.push_back(hs + 2);
    abort = 1'b1;
    do_read(4'd5, 16'h0205, 16'h0305, "commit_cycle_old");
    abort = 1'b0;
    do_read(4'd5, 16'h0405, 16'h0505, "after_commit_new");
    chk_status("load3_done_status", 1'b0, 1'b1, 1'b0);
    tick();

    // Load 4: stray load_req at word 5, rst at word 12.
    load_req = 1'b1; tick(); load_req = 1'b0;
    for (int w = 0; w < 12; w++) begin
      if (w == 5) begin
        load_req = 1'b1;
      end
      send_word(16'(16'h0600 + w), 1'b0, hs);
      load_req = 1'b0;
    end
    s_data  = 16'h060c;
    s_valid = 1'b1;
    rst     = 1'b1;
    tick();
    rst     = 1'b0;
    s_valid = 1'b0;
    chk_status("post_rst_status", 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      do_read(4'(i), 16'h0000, 16'h0000, "post_rst_read");
    end
    do_read(4'd12, 16'h0000, 16'h0000, "post_rst_clamp");
    repeat (3) tick();

    checks++;
    if (done_q.size() != 0) begin
      errors++;
      $display("FAIL load_done_missing: %0d pulses outstanding, expected 0", done_q.size());
    end
    checks++;
    if (rd_q.size() != 0) begin
      errors++;
      $display("FAIL rd_missing: %0d reads outstanding, expected 0", rd_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
